pool_sequencer: RTL and testbench

Controller that sequences the pooling stage on the systolic array output path. It accepts result rows, performs element-wise signed max pooling over a configurable window of consecutive rows, and emits one pooled row per window. It counts rows against a programmed total and signals completion to the top-level control FSM. With pooling disabled it acts as a one-cycle registered pass-through with the same row counting and done signalling.

---
 rtl/pool_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pool_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_sequencer.sv
// Pooling-stage sequencer for the systolic array output path.
// Max-pools consecutive result rows per lane over a 1/2/4-row window.
//
// Ports:
//   clk, reset (async, active-low)
//   start              : one-cycle pulse, begins a run when idle
//   enable_pool        : 1 = pool, 0 = bypass (window of 1)
//   pool_window        : 00=1, 01=2, 10/11=4
//   num_rows           : total input rows of the run
//   validity_mask      : lane i forced to 0 on output when bit i is 0
//   in_data_available  : inp_data valid this cycle
//   inp_data           : input row, lane i at [i*DWIDTH +: DWIDTH]
//   out_data           : pooled row, held between pulses
//   out_data_available : one-cycle pulse per pooled row
//   done_pool          : sticky run-complete flag
//   busy               : run in progress
module pool_sequencer #(
    parameter int MAT_MUL_SIZE = 4,
    parameter int DWIDTH       = 8,
    parameter int MASK_WIDTH   = 4,
    parameter int ROW_CNT_W    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           enable_pool,
    input  logic [1:0]                     pool_window,
    input  logic [ROW_CNT_W-1:0]           num_rows,
    input  logic [MASK_WIDTH-1:0]          validity_mask,
    input  logic                           in_data_available,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_data_available,
    output logic                           done_pool,
    output logic                           busy
);

    localparam int RW = MAT_MUL_SIZE * DWIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FINISH
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             win_q, win_d;
    logic [ROW_CNT_W-1:0]   num_q, num_d;
    logic [MASK_WIDTH-1:0]  mask_q, mask_d;
    logic [ROW_CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic [1:0]             win_cnt_q, win_cnt_d;
    logic [RW-1:0]          acc_q, acc_d;
    logic [RW-1:0]          out_q, out_d;
    logic                   vld_q, vld_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [RW-1:0]          acc_new;
    logic [RW-1:0]          acc_masked;
    logic [2:0]             win_start;
    logic                   last_row;
    logic                   win_close;

    // Effective window decoded once at start; bypass collapses to 1.
    always_comb begin
        win_start = 3'd1;
        if (enable_pool) begin
            unique case (pool_window)
                2'b00:   win_start = 3'd1;
                2'b01:   win_start = 3'd2;
                default: win_start = 3'd4;
            endcase
        end
    end

    // First row of a window seeds the accumulator; later rows max in.
    // Ties keep the stored value.
    always_comb begin
        acc_new    = acc_q;
        acc_masked = '0;
        for (int i = 0; i < MAT_MUL_SIZE; i++) begin
            if (win_cnt_q == 2'd0) begin
                acc_new[i*DWIDTH +: DWIDTH] = inp_data[i*DWIDTH +: DWIDTH];
            end else if ($signed(inp_data[i*DWIDTH +: DWIDTH]) >
                         $signed(acc_q[i*DWIDTH +: DWIDTH])) begin
                acc_new[i*DWIDTH +: DWIDTH] = inp_data[i*DWIDTH +: DWIDTH];
            end
            if (mask_q[i]) begin
                acc_masked[i*DWIDTH +: DWIDTH] = acc_new[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign last_row  = (row_cnt_q == num_q - ROW_CNT_W'(1));
    assign win_close = ({1'b0, win_cnt_q} == win_q - 3'd1) || last_row;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        num_d     = num_q;
        mask_d    = mask_q;
        row_cnt_d = row_cnt_q;
        win_cnt_d = win_cnt_q;
        acc_d     = acc_q;
        out_d     = out_q;
        vld_d     = 1'b0;
        done_d    = done_q;
        busy_d    = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    win_d     = win_start;
                    num_d     = num_rows;
                    mask_d    = validity_mask;
                    row_cnt_d = '0;
                    win_cnt_d = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = (num_rows == '0) ? S_FINISH : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_data_available) begin
                    acc_d     = acc_new;
                    row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
                    win_cnt_d = win_cnt_q + 2'd1;
                    if (win_close) begin
                        win_cnt_d = '0;
                        out_d     = acc_masked;
                        vld_d     = 1'b1;
                    end
                    if (last_row) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q     <= 3'd1;
            num_q     <= '0;
            mask_q    <= '0;
            row_cnt_q <= '0;
            win_cnt_q <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            win_q     <= win_d;
            num_q     <= num_d;
            mask_q    <= mask_d;
            row_cnt_q <= row_cnt_d;
            win_cnt_q <= win_cnt_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign out_data           = out_q;
    assign out_data_available = vld_q;
    assign done_pool          = done_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_pool_sequencer.sv
// Self-checking bench for pool_sequencer.
// Reference: per-window lane max computed from the row list.
module tb_pool_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        enable_pool;
    logic [1:0]  pool_window;
    logic [7:0]  num_rows;
    logic [3:0]  validity_mask;
    logic        in_data_available;
    logic [31:0] inp_data;
    logic [31:0] out_data;
    logic        out_data_available;
    logic        done_pool;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    pool_sequencer #(
        .MAT_MUL_SIZE(4),
        .DWIDTH      (8),
        .MASK_WIDTH  (4),
        .ROW_CNT_W   (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .enable_pool       (enable_pool),
        .pool_window       (pool_window),
        .num_rows          (num_rows),
        .validity_mask     (validity_mask),
        .in_data_available (in_data_available),
        .inp_data          (inp_data),
        .out_data          (out_data),
        .out_data_available(out_data_available),
        .done_pool         (done_pool),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Lane-wise signed max over rows[lo..hi-1], masked lanes zeroed.
    function automatic logic [31:0] pool_ref(input logic [31:0] rows[$],
                                             input int lo, input int hi,
                                             input logic [3:0] m);
        logic [31:0]       r;
        logic [31:0]       row;
        logic signed [7:0] b;
        int                best;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            row  = rows[lo];
            b    = row[l*8 +: 8];
            best = int'(b);
            for (int k = lo + 1; k < hi; k++) begin
                row = rows[k];
                b   = row[l*8 +: 8];
                if (int'(b) > best) best = int'(b);
            end
            if (m[l]) r[l*8 +: 8] = best[7:0];
        end
        return r;
    endfunction

    task automatic run(input logic en, input logic [1:0] pw, input int n,
                       input logic [3:0] m, input logic [31:0] rows[$],
                       input int gap_mode, input bit chaos,
                       output int pulses);
        int          w;
        int          j;
        bit          feed;
        bit          tog;
        bit          closes;
        logic [31:0] expq[$];
        w = !en ? 1 : (pw == 2'b00 ? 1 : (pw == 2'b01 ? 2 : 4));
        for (int k = 0; k < n; k += w) begin
            expq.push_back(pool_ref(rows, k, (k + w < n) ? k + w : n, m));
        end
        pulses = 0;
        start             = 1'b1;
        enable_pool       = en;
        pool_window       = pw;
        num_rows          = n[7:0];
        validity_mask     = m;
        in_data_available = 1'b1;
        inp_data          = $urandom;
        step;
        start             = 1'b0;
        in_data_available = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done_pool), 32'd0);
        chk("no_pulse_start", 32'(out_data_available), 32'd0);
        j   = 0;
        tog = 1'b0;
        while (j < n) begin
            if (gap_mode == 0) begin
                feed = 1'b1;
            end else if (gap_mode == 1) begin
                feed = tog;
                tog  = ~tog;
            end else begin
                feed = ($urandom_range(0, 2) != 0);
            end
            if (chaos) begin
                pool_window   = 2'($urandom);
                enable_pool   = 1'($urandom);
                num_rows      = 8'($urandom);
                validity_mask = 4'($urandom);
                start         = ($urandom_range(0, 3) == 0);
            end
            in_data_available = feed;
            inp_data          = feed ? rows[j] : $urandom;
            step;
            closes = 1'b0;
            if (feed) begin
                closes = ((j + 1) % w == 0) || (j == n - 1);
                j++;
            end
            chk("pulse", 32'(out_data_available), 32'(closes));
            if (closes) begin
                last_exp = expq.pop_front();
                pulses++;
            end
            chk("out_data", out_data, last_exp);
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done_pool), 32'd0);
        end
        start             = 1'b0;
        in_data_available = 1'b0;
        step;
        chk("done_set", 32'(done_pool), 32'd1);
        chk("busy_clr", 32'(busy), 32'd0);
        chk("no_pulse_fin", 32'(out_data_available), 32'd0);
        for (int c = 0; c < 3; c++) begin
            in_data_available = 1'($urandom);
            inp_data          = $urandom;
            step;
            chk("idle_pulse", 32'(out_data_available), 32'd0);
            chk("idle_done", 32'(done_pool), 32'd1);
            chk("idle_hold", out_data, last_exp);
        end
        in_data_available = 1'b0;
        chk("pulse_count", 32'(pulses), 32'((n + w - 1) / w));
    endtask

    initial begin
        logic [31:0] rows[$];
        int          p;
        int          n;
        reset             = 1'b0;
        start             = 1'b0;
        enable_pool       = 1'b0;
        pool_window       = 2'b00;
        num_rows          = '0;
        validity_mask     = '0;
        in_data_available = 1'b0;
        inp_data          = '0;
        #12;
        chk("rst_out", out_data, 32'd0);
        chk("rst_vld", 32'(out_data_available), 32'd0);
        chk("rst_done", 32'(done_pool), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10;
        reset = 1'b1;
        step;

        // W=2, hand-computed rows and results
        rows.delete();
        rows.push_back(32'h0003FB01);
        rows.push_back(32'h07FFFD02);
        rows.push_back(32'hFF0404F8);
        rows.push_back(32'hFE0206F7);
        run(1'b1, 2'b01, 4, 4'hF, rows, 0, 1'b0, p);
        chk("w2_last_const", out_data, 32'hFF0406F8);

        // bypass with gaps; window setting must not matter
        rows.delete();
        for (int i = 0; i < 3; i++) rows.push_back($urandom);
        run(1'b0, 2'b10, 3, 4'hF, rows, 1, 1'b0, p);
        chk("bypass_last", out_data, rows[2]);

        // W=4 partial last window, lanes 1 and 3 masked
        rows.delete();
        for (int i = 0; i < 6; i++) rows.push_back($urandom);
        run(1'b1, 2'b10, 6, 4'b0101, rows, 0, 1'b0, p);

        // zero rows
        rows.delete();
        run(1'b1, 2'b01, 0, 4'hF, rows, 0, 1'b0, p);

        // config churn and start pulses mid-run
        rows.delete();
        for (int i = 0; i < 7; i++) rows.push_back($urandom);
        run(1'b1, 2'b01, 7, 4'b1011, rows, 2, 1'b1, p);

        // random runs
        for (int r = 0; r < 8; r++) begin
            rows.delete();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) rows.push_back($urandom);
            run(1'($urandom), 2'($urandom), n, 4'($urandom), rows,
                $urandom_range(0, 2), 1'($urandom), p);
        end

        // reset mid-run after 2 of 4 rows, then a clean short run
        start         = 1'b1;
        enable_pool   = 1'b1;
        pool_window   = 2'b10;
        num_rows      = 8'd4;
        validity_mask = 4'hF;
        step;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data_available = 1'b1;
            inp_data          = 32'h7F7F7F7F;
            step;
        end
        in_data_available = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out", out_data, 32'd0);
        chk("midrst_vld", 32'(out_data_available), 32'd0);
        chk("midrst_done", 32'(done_pool), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        last_exp = '0;
        #3;
        reset = 1'b1;
        step;
        rows.delete();
        for (int i = 0; i < 2; i++) rows.push_back($urandom & 32'h7F7F7F7F ^ 32'h80808080);
        run(1'b1, 2'b10, 2, 4'hF, rows, 0, 1'b0, p);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
